// File: rtl/rx_code_correlator.sv
// rx_code_correlator: local modulo-1023 C/A code NCO with early/prompt/late correlators,
// dumping saturated sums once per code epoch; supports chip-slip for acquisition search.
module rx_code_correlator #(
    parameter int NACC  = 16,
    parameter int NFRAC = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [5:0]       ca_sel,
    input  logic             dv_in,
    input  logic             sample_i,
    input  logic [NFRAC-1:0] freq,
    input  logic             slip_req,
    input  logic [9:0]       slip_chips,
    output logic             dv_out,
    output logic [NACC-1:0]  corr_e,
    output logic [NACC-1:0]  corr_p,
    output logic [NACC-1:0]  corr_l,
    output logic [15:0]      epoch_cnt,
    output logic             slip_pending,
    output logic             overrun
);
    typedef enum logic [2:0] {IDLE, RD_E, RD_P, RD_L, ACC} state_t;

    // One full 1023-chip period of a 10-stage LFSR (all-ones seed, stage-10 output), bit 0 first.
    function automatic logic [1022:0] lfsr_seq(input logic [9:0] taps);
        logic [9:0]    s;
        logic [1022:0] q;
        s = '1;
        q = '0;
        for (int o = 0; o < 33; o++)
            for (int j = 0; j < 31; j++) begin
                q = {s[9], q[1022:1]};
                s = {s[8:0], ^(s & taps)};
            end
        return q;
    endfunction

    localparam logic [1022:0] G1 = lfsr_seq(10'h204);
    localparam logic [1022:0] G2 = lfsr_seq(10'h3A6);
    // G2 chip delays for PRN 36 (left) down to PRN 1 (right); ROM bit ca_sel is PRN ca_sel+1.
    localparam logic [35:0][9:0] G2_DLY = {
        10'd948, 10'd947, 10'd950, 10'd863, 10'd862, 10'd861, 10'd860, 10'd859,
        10'd516, 10'd515, 10'd514, 10'd513, 10'd512, 10'd509, 10'd474, 10'd473,
        10'd472, 10'd471, 10'd470, 10'd469, 10'd258, 10'd257, 10'd256, 10'd255,
        10'd254, 10'd252, 10'd251, 10'd141, 10'd140, 10'd139, 10'd18,  10'd17,
        10'd8,   10'd7,   10'd6,   10'd5};
    localparam logic signed [NACC-1:0] ONE = NACC'(1);
    localparam logic signed [NACC-1:0] MAX = {1'b0, {(NACC-1){1'b1}}};

    function automatic logic signed [NACC-1:0] sat_step(input logic signed [NACC-1:0] a, input logic up);
        return up ? (a == MAX ? a : a + ONE) : (a == -MAX ? a : a - ONE);
    endfunction

    state_t state;
    logic [9:0] idx, p_idx, e_idx, l_idx, prev_idx, slip_val, e_nxt, l_nxt, rom_addr, g2_addr, idx_nxt;
    logic [NFRAC-1:0] frac;
    logic [NFRAC:0] frac_sum;
    logic [10:0] idx_sum, g2_sum;
    logic sample_q, apply_q, discard, chip_e, chip_p, rom_q, m_e, m_p, m_l, boundary;
    logic signed [NACC-1:0] acc_e, acc_p, acc_l;

    always_comb begin
        frac_sum = {1'b0, frac} + {1'b0, freq};
        idx_sum  = 11'(idx) + 11'(frac_sum[NFRAC]) + (slip_pending ? 11'(slip_val) : 11'd0);
        idx_nxt  = idx_sum >= 11'd1023 ? 10'(idx_sum - 11'd1023) : idx_sum[9:0];
        e_nxt    = frac[NFRAC-1] ? (idx == 10'd1022 ? 10'd0 : idx + 10'd1) : idx;
        l_nxt    = frac[NFRAC-1] ? idx : (idx == 10'd0 ? 10'd1022 : idx - 10'd1);
        rom_addr = state == RD_E ? e_idx : state == RD_P ? p_idx : l_idx;
        g2_sum   = 11'(rom_addr) + 11'd1023 - 11'(G2_DLY[ca_sel]);
        g2_addr  = g2_sum >= 11'd1023 ? 10'(g2_sum - 11'd1023) : g2_sum[9:0];
        m_e      = sample_q == chip_e;
        m_p      = sample_q == chip_p;
        m_l      = sample_q == rom_q;
        boundary = p_idx < prev_idx;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) rom_q <= 1'b0;
        else         rom_q <= G1[rom_addr] ^ G2[g2_addr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            idx          <= '0;
            frac         <= '0;
            p_idx        <= '0;
            e_idx        <= '0;
            l_idx        <= '0;
            prev_idx     <= '0;
            slip_val     <= '0;
            sample_q     <= 1'b0;
            apply_q      <= 1'b0;
            discard      <= 1'b0;
            chip_e       <= 1'b0;
            chip_p       <= 1'b0;
            acc_e        <= '0;
            acc_p        <= '0;
            acc_l        <= '0;
            dv_out       <= 1'b0;
            corr_e       <= '0;
            corr_p       <= '0;
            corr_l       <= '0;
            epoch_cnt    <= '0;
            slip_pending <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            dv_out <= 1'b0;
            if (dv_in && state != IDLE) overrun <= 1'b1;
            if (slip_req) begin
                slip_pending <= 1'b1;
                slip_val     <= slip_chips;
            end else if (dv_in && state == IDLE) slip_pending <= 1'b0;
            case (state)
                IDLE: if (dv_in) begin
                    sample_q <= sample_i;
                    p_idx    <= idx;
                    e_idx    <= e_nxt;
                    l_idx    <= l_nxt;
                    apply_q  <= slip_pending;
                    frac     <= frac_sum[NFRAC-1:0];
                    idx      <= idx_nxt;
                    state    <= RD_E;
                end
                RD_E: state <= RD_P;
                RD_P: begin
                    chip_e <= rom_q;
                    state  <= RD_L;
                end
                RD_L: begin
                    chip_p <= rom_q;
                    state  <= ACC;
                end
                ACC: begin
                    state <= IDLE;
                    // A zero previous index masks the wrap the slip itself may cause.
                    if (apply_q) begin
                        acc_e    <= '0;
                        acc_p    <= '0;
                        acc_l    <= '0;
                        prev_idx <= '0;
                        discard  <= 1'b1;
                    end else if (boundary) begin
                        acc_e    <= m_e ? ONE : -ONE;
                        acc_p    <= m_p ? ONE : -ONE;
                        acc_l    <= m_l ? ONE : -ONE;
                        prev_idx <= p_idx;
                        discard  <= 1'b0;
                        if (!discard) begin
                            corr_e    <= acc_e;
                            corr_p    <= acc_p;
                            corr_l    <= acc_l;
                            dv_out    <= 1'b1;
                            epoch_cnt <= epoch_cnt + 16'd1;
                        end
                    end else begin
                        acc_e    <= sat_step(acc_e, m_e);
                        acc_p    <= sat_step(acc_p, m_p);
                        acc_l    <= sat_step(acc_l, m_l);
                        prev_idx <= p_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_code_correlator.sv
// tb_rx_code_correlator: random and directed stimulus against a phase-arithmetic reference
// model; expected dumps go through a scoreboard queue checked by an independent monitor.
`timescale 1ns/1ps
module tb_rx_code_correlator;
    logic clk = 0, resetn = 1, dv_in = 0, sample_i = 0, slip_req = 0;
    logic [5:0] ca_sel = 0;
    logic [31:0] freq = 0;
    logic [9:0] slip_chips = 0;
    logic dv_out, slip_pending, overrun, dv_out8, slip_pending8, overrun8;
    logic signed [15:0] corr_e, corr_p, corr_l;
    logic signed [7:0] c8_e, c8_p, c8_l;
    logic [15:0] epoch_cnt, epoch_cnt8;

    rx_code_correlator dut (.clk(clk), .resetn(resetn), .ca_sel(ca_sel), .dv_in(dv_in),
        .sample_i(sample_i), .freq(freq), .slip_req(slip_req), .slip_chips(slip_chips),
        .dv_out(dv_out), .corr_e(corr_e), .corr_p(corr_p), .corr_l(corr_l),
        .epoch_cnt(epoch_cnt), .slip_pending(slip_pending), .overrun(overrun));
    rx_code_correlator #(.NACC(8)) dut8 (.clk(clk), .resetn(resetn), .ca_sel(ca_sel), .dv_in(dv_in),
        .sample_i(sample_i), .freq(freq), .slip_req(slip_req), .slip_chips(slip_chips),
        .dv_out(dv_out8), .corr_e(c8_e), .corr_p(c8_p), .corr_l(c8_l),
        .epoch_cnt(epoch_cnt8), .slip_pending(slip_pending8), .overrun(overrun8));

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // C/A code table: G1 xor delayed G2, both from 10-stage registers seeded with ones.
    bit code[36][1023];
    int dly[36] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258, 469, 470,
                    471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862, 863, 950, 947, 948};
    task automatic build_codes();
        bit g1[1023], g2[1023];
        bit [1:10] r1 = '1, r2 = '1;
        for (int i = 0; i < 1023; i++) begin
            g1[i] = r1[10];
            g2[i] = r2[10];
            r1 = {r1[3] ^ r1[10], r1[1:9]};
            r2 = {r2[2] ^ r2[3] ^ r2[6] ^ r2[8] ^ r2[9] ^ r2[10], r2[1:9]};
        end
        for (int s = 0; s < 36; s++)
            for (int i = 0; i < 1023; i++) code[s][i] = g1[i] ^ g2[(i - dly[s] + 1023) % 1023];
    endtask

    typedef struct {int e, p, l, e8, p8, l8, cnt, at;} exp_t;
    exp_t sbq[$];

    // Reference model: phase in units of 2^-32 chip, modulo 1023 chips.
    localparam longint M = 64'd1023 << 32;
    localparam longint H = 64'h8000_0000;
    longint ph, tx_ph;
    int prev_p, sval, ecnt, last_acc;
    bit skip, discard, spend, ovr_m;
    int a16[3], a8[3];

    function automatic int sat(input int x, input int n);
        int mx = (1 << (n - 1)) - 1;
        return x > mx ? mx : (x < -mx ? -mx : x);
    endfunction

    task automatic model_reset();
        ph = 0; tx_ph = 0; prev_p = 0; sval = 0; ecnt = 0; last_acc = -100;
        skip = 0; discard = 0; spend = 0; ovr_m = 0;
        for (int k = 0; k < 3; k++) begin a16[k] = 0; a8[k] = 0; end
    endtask

    task automatic model_step(input bit s, input int n);
        int idx[3], pr[3], amt;
        bit apply;
        if (n - last_acc < 5) begin
            ovr_m = 1;
            return;
        end
        last_acc = n;
        idx[0] = int'(((ph + H) % M) >> 32);
        idx[1] = int'(ph >> 32);
        idx[2] = int'(((ph + M - H) % M) >> 32);
        for (int k = 0; k < 3; k++) pr[k] = (s == code[ca_sel][idx[k]]) ? 1 : -1;
        apply = spend; amt = sval; spend = 0;
        if (apply) begin
            for (int k = 0; k < 3; k++) begin a16[k] = 0; a8[k] = 0; end
            discard = 1;
        end else if (!skip && idx[1] < prev_p) begin
            if (!discard) begin
                ecnt++;
                sbq.push_back('{a16[0], a16[1], a16[2], a8[0], a8[1], a8[2], ecnt, n + 5});
            end
            discard = 0;
            for (int k = 0; k < 3; k++) begin a16[k] = pr[k]; a8[k] = pr[k]; end
        end else
            for (int k = 0; k < 3; k++) begin
                a16[k] = sat(a16[k] + pr[k], 16);
                a8[k] = sat(a8[k] + pr[k], 8);
            end
        skip = apply;
        prev_p = idx[1];
        ph = (ph + longint'(freq) + (apply ? longint'(amt) << 32 : 64'd0)) % M;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (resetn && (dv_out || dv_out8)) chk("dv_out_match", int'(dv_out8), int'(dv_out));
        if (resetn && dv_out) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_dv_out: got pulse, expected none (cycle %0d)", cyc);
            end else begin
                x = sbq.pop_front();
                chk("dump_cycle", cyc, x.at);
                chk("corr_e", int'(corr_e), x.e);
                chk("corr_p", int'(corr_p), x.p);
                chk("corr_l", int'(corr_l), x.l);
                chk("epoch_cnt", int'(epoch_cnt), x.cnt);
                chk("corr8_e", int'(c8_e), x.e8);
                chk("corr8_p", int'(c8_p), x.p8);
                chk("corr8_l", int'(c8_l), x.l8);
                chk("epoch_cnt8", int'(epoch_cnt8), x.cnt);
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].at) begin
            checks++; errors++;
            $display("FAIL missing_dv_out: got none, expected pulse at cycle %0d", sbq[0].at);
            void'(sbq.pop_front());
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit s, input int gap);
        dv_in = 1; sample_i = s;
        model_step(s, cyc);
        tick(1);
        dv_in = 0;
        if (gap > 1) tick(gap - 1);
    endtask

    task automatic run(input int n, input bit inv, input int gap);
        for (int i = 0; i < n; i++) begin
            send(code[ca_sel][int'(tx_ph >> 32)] ^ inv, gap);
            tx_ph = (tx_ph + longint'(freq)) % M;
        end
    endtask

    task automatic slip(input int v);
        slip_req = 1; slip_chips = 10'(v);
        spend = 1; sval = v;
        tick(1);
        slip_req = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dv_out"}, int'(dv_out), 0);
        chk({tag, "_corr_e"}, int'(corr_e), 0);
        chk({tag, "_corr_p"}, int'(corr_p), 0);
        chk({tag, "_corr_l"}, int'(corr_l), 0);
        chk({tag, "_epoch_cnt"}, int'(epoch_cnt), 0);
        chk({tag, "_slip_pending"}, int'(slip_pending), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
    endtask

    task automatic do_reset();
        tick(8);
        chk("sb_empty_before_reset", sbq.size(), 0);
        sbq.delete();
        resetn = 0;
        #1;
        chk_zero("reset");
        tick(2);
        resetn = 1;
        model_reset();
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        build_codes();
        model_reset();
        #2 resetn = 0;
        tick(3);
        chk_zero("por");
        resetn = 1;
        tick(1);

        // Inverted replica, two full epochs, then a reset landing in RD_P mid-epoch.
        ca_sel = 0; freq = 32'h8000_0000;
        run(4093, 1, 5);
        tick(8);
        chk("inv_corr_p", int'(corr_p), -2046);
        chk("inv_epoch_cnt", int'(epoch_cnt), 2);
        run(300, 1, 5);
        tick(8);
        chk("sb_empty_midreset", sbq.size(), 0);
        dv_in = 1; tick(1); dv_in = 0; tick(1);
        resetn = 0;
        #1;
        chk_zero("midfsm");
        tick(3);
        resetn = 1;
        model_reset();
        tick(1);

        // Aligned replica from reset: peak correlation and 8-bit saturation.
        run(2047, 0, 5);
        tick(8);
        chk("aligned_corr_p", int'(corr_p), 2046);
        chk("aligned_epoch_cnt", int'(epoch_cnt), 1);
        chk("aligned_corr8_p", int'(c8_p), 127);

        // One-chip slip at sample 500 with the transmitted stream left unslipped.
        do_reset();
        run(500, 0, 5);
        slip(1);
        chk("slip_pending_set", int'(slip_pending), 1);
        run(1, 0, 5);
        chk("slip_pending_clear", int'(slip_pending), 0);
        run(3700, 0, 5);
        tick(8);
        chk("slip_epoch_cnt", int'(epoch_cnt), 1);

        // Pulses 3 clk apart: alternate pulses dropped, overrun sticky until reset.
        do_reset();
        ca_sel = 6'($urandom_range(0, 35));
        freq = 32'hF000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
        for (int i = 0; i < 20; i++) send(1'($urandom), 3);
        tick(5);
        chk("overrun_set", int'(overrun), 1);
        chk("overrun_model", int'(overrun), int'(ovr_m));
        for (int i = 0; i < 1500; i++) send(1'($urandom), 5);
        tick(8);
        chk("overrun_held", int'(overrun), 1);
        chk("sb_empty_overrun", sbq.size(), 0);
        resetn = 0;
        #1;
        chk("overrun_reset", int'(overrun), 0);
        tick(2);
        resetn = 1;
        model_reset();
        tick(1);

        // Random code, rate, gaps and slips; mostly aligned so sums stay nontrivial.
        ca_sel = 6'($urandom_range(0, 35));
        freq = 32'hC000_0000 + 32'($urandom_range(0, 32'h3FFF_FFFF));
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) slip(int'($urandom_range(0, 1022)));
            send(($urandom_range(0, 3) == 0) ? 1'($urandom) : code[ca_sel][int'(tx_ph >> 32)],
                 int'($urandom_range(5, 7)));
            tx_ph = (tx_ph + longint'(freq)) % M;
        end
        tick(10);
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
